// File: rtl/shift_arbiter_pkg.sv
// Shared types and constants for the FPHUB shift arbiter slice.
package shift_arb_pkg;

    // Source tag carried with every result and used for round-robin history.
    typedef enum logic {
        SRC_ALIGN = 1'b0,
        SRC_NORM  = 1'b1
    } shift_src_t;

    // Shifter direction encodings for the right_shift control input.
    localparam logic SHIFT_DIR_LEFT  = 1'b0;
    localparam logic SHIFT_DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_arbiter_if.sv
// Handshake bundle between the two shift requesters, the arbiter and the
// result consumer. The arbiter uses the slave view, the environment the master.
interface shift_arbiter_if
    import shift_arb_pkg::*;
#(
    parameter int W  = 30,
    parameter int AW = 9
);
    logic          align_valid;
    logic          align_ready;
    logic [W-1:0]  align_data;
    logic [AW-1:0] align_amount;
    logic          align_arith;

    logic          norm_valid;
    logic          norm_ready;
    logic [W-1:0]  norm_data;
    logic [AW-1:0] norm_amount;

    logic          res_valid;
    logic          res_ready;
    logic [W-1:0]  res_data;
    shift_src_t    res_src;

    modport slave (
        input  align_valid, align_data, align_amount, align_arith,
        output align_ready,
        input  norm_valid, norm_data, norm_amount,
        output norm_ready,
        output res_valid, res_data, res_src,
        input  res_ready
    );

    modport master (
        output align_valid, align_data, align_amount, align_arith,
        input  align_ready,
        output norm_valid, norm_data, norm_amount,
        input  norm_ready,
        input  res_valid, res_data, res_src,
        output res_ready
    );

endinterface

// File: rtl/shift_arbiter_shifter.sv
// Combinational barrel shifter shared by alignment and normalization.
// Oversized amounts saturate: left/logical-right give zero, arithmetic right
// gives sign fill.
module shifter
    import shift_arb_pkg::*;
#(
    parameter int M                   = 23,
    parameter int E                   = 8,
    parameter int extra_bits_mantissa = 7
) (
    input  logic [M+extra_bits_mantissa-1:0] data_in,
    input  logic [E:0]                       amount,
    input  logic                             right_shift,
    input  logic                             arithmetic_shift,
    input  logic                             print,
    output logic [M+extra_bits_mantissa-1:0] data_out
);
    // The print hook is a debug input of the original shifter and has no
    // effect on the datapath here.
    logic unused_print;
    assign unused_print = print;

    // Select the shift flavour; SV shift operators already saturate for
    // amounts at or beyond the data width.
    always_comb begin
        data_out = data_in << amount;
        if (right_shift == SHIFT_DIR_RIGHT) begin
            if (arithmetic_shift) begin
                data_out = $signed(data_in) >>> amount;
            end else begin
                data_out = data_in >> amount;
            end
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// Arbiter sharing one shifter between exponent alignment (right shift) and
// post-add normalization (left shift), with a one-entry tagged result register.
// Build option: define SHIFT_ARB_RR_EN for round-robin tie-break; otherwise
// alignment has fixed priority on ties.
module shift_arbiter
    import shift_arb_pkg::*;
#(
    parameter int M                   = 23,
    parameter int E                   = 8,
    parameter int extra_bits_mantissa = 7
) (
    input  logic            clk,
    input  logic            rst,
    shift_arbiter_if.slave  bus
);
    localparam int W = M + extra_bits_mantissa;

    logic         slot_free;
    logic         align_wins;
    logic         align_fire;
    logic         norm_fire;

    logic [W-1:0] sh_in;
    logic [E:0]   sh_amount;
    logic         sh_right;
    logic         sh_arith;
    logic [W-1:0] sh_out;

    logic         res_valid_q;
    logic [W-1:0] res_data_q;
    shift_src_t   res_src_q;

`ifdef SHIFT_ARB_RR_EN
    shift_src_t   last_grant;

    // Remember who was granted last so the other side wins the next tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= SRC_NORM;
        end else if (align_fire) begin
            last_grant <= SRC_ALIGN;
        end else if (norm_fire) begin
            last_grant <= SRC_NORM;
        end
    end

    assign align_wins = (last_grant == SRC_NORM);
`else
    assign align_wins = 1'b1;
`endif

    // A ready never looks at its own valid, only at the slot and the rival,
    // so at most one transfer can happen per cycle.
    always_comb begin
        slot_free       = !res_valid_q || bus.res_ready;
        bus.align_ready = !rst && slot_free && (!bus.norm_valid || align_wins);
        bus.norm_ready  = !rst && slot_free && (!bus.align_valid || !align_wins);
        align_fire      = bus.align_valid && bus.align_ready;
        norm_fire       = bus.norm_valid && bus.norm_ready;
    end

    // Steer the granted request into the shared shifter.
    always_comb begin
        sh_in     = bus.align_data;
        sh_amount = bus.align_amount;
        sh_right  = SHIFT_DIR_RIGHT;
        sh_arith  = bus.align_arith;
        if (norm_fire) begin
            sh_in     = bus.norm_data;
            sh_amount = bus.norm_amount;
            sh_right  = SHIFT_DIR_LEFT;
            sh_arith  = 1'b0;
        end
    end

    shifter #(
        .M                   (M),
        .E                   (E),
        .extra_bits_mantissa (extra_bits_mantissa)
    ) u_shifter (
        .data_in          (sh_in),
        .amount           (sh_amount),
        .right_shift      (sh_right),
        .arithmetic_shift (sh_arith),
        .print            (1'b0),
        .data_out         (sh_out)
    );

    // Capture a transfer into the result slot; a drain without a new transfer
    // only clears valid so data and tag keep their last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_src_q   <= SRC_ALIGN;
        end else if (align_fire || norm_fire) begin
            res_valid_q <= 1'b1;
            res_data_q  <= sh_out;
            res_src_q   <= norm_fire ? SRC_NORM : SRC_ALIGN;
        end else if (bus.res_ready) begin
            res_valid_q <= 1'b0;
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_src   = res_src_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter with a behavioural reference model.
// Follows the SHIFT_ARB_RR_EN build option for tie-break expectations.
module tb_shift_arbiter;
    import shift_arb_pkg::*;

    localparam int W  = 30;
    localparam int AW = 9;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    bit           m_valid;
    logic [W-1:0] m_data;
    bit           m_src;
    bit           m_last_norm;

    shift_arbiter_if #(.W(W), .AW(AW)) bus ();

    shift_arbiter #(
        .M                   (23),
        .E                   (8),
        .extra_bits_mantissa (7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Reference shift computed with multiply/divide arithmetic.
    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int amt,
                                               input bit right, input bit arith);
        longint unsigned v;
        longint unsigned p;
        longint unsigned full;
        v    = d;
        full = (64'd1 << W) - 64'd1;
        p    = 1;
        if (amt >= W) begin
            if (right && arith && d[W-1]) return '1;
            return '0;
        end
        for (int i = 0; i < amt; i++) p = p * 2;
        if (!right) return W'((v * p) % (full + 1));
        if (arith && d[W-1]) return W'(full - (full - v) / p);
        return W'(v / p);
    endfunction

    // Which requester should transfer this cycle given the model state.
    function automatic void predict(output bit a_fire, output bit n_fire);
        bit slot;
        bit align_first;
        a_fire = 1'b0;
        n_fire = 1'b0;
        slot   = !m_valid || bus.res_ready;
`ifdef SHIFT_ARB_RR_EN
        align_first = m_last_norm;
`else
        align_first = 1'b1;
`endif
        if (!rst && slot) begin
            if (bus.align_valid && bus.norm_valid) begin
                a_fire = align_first;
                n_fire = !align_first;
            end else begin
                a_fire = bus.align_valid;
                n_fire = bus.norm_valid;
            end
        end
    endfunction

    task automatic drive(input bit av, input logic [W-1:0] ad, input int aamt, input bit aar,
                         input bit nv, input logic [W-1:0] nd, input int namt, input bit rr);
        bus.align_valid  = av;
        bus.align_data   = ad;
        bus.align_amount = AW'(aamt);
        bus.align_arith  = aar;
        bus.norm_valid   = nv;
        bus.norm_data    = nd;
        bus.norm_amount  = AW'(namt);
        bus.res_ready    = rr;
        #1;
    endtask

    task automatic advance();
        bit af;
        bit nf;
        predict(af, nf);
        if (rst) begin
            m_valid     = 1'b0;
            m_data      = '0;
            m_src       = 1'b0;
            m_last_norm = 1'b1;
        end else if (af) begin
            m_data      = ref_shift(bus.align_data, int'(bus.align_amount), 1'b1, bus.align_arith);
            m_src       = 1'b0;
            m_valid     = 1'b1;
            m_last_norm = 1'b0;
        end else if (nf) begin
            m_data      = ref_shift(bus.norm_data, int'(bus.norm_amount), 1'b0, 1'b0);
            m_src       = 1'b1;
            m_valid     = 1'b1;
            m_last_norm = 1'b1;
        end else if (bus.res_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 30'h1234, 3, 0, 1, 30'h5678, 2, 1);
        checks++;
        if ({bus.align_ready, bus.norm_ready} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_readys: got %b expected 00", {bus.align_ready, bus.norm_ready});
        end
        advance();
        advance();
        checks++;
        if (bus.res_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_valid: got %b expected 0", bus.res_valid);
        end
        checks++;
        if (bus.res_data !== '0 || bus.res_src !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_data_src: got %h/%b expected 0/0", bus.res_data, bus.res_src);
        end
        rst = 1'b0;
        drive(0, '0, 0, 0, 0, '0, 0, 1);
    endtask

    task automatic test_align_basic();
        drive(1, 30'h2000_0000, 4, 1, 0, '0, 0, 1);
        checks++;
        if (bus.align_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL align_ready: got %b expected 1", bus.align_ready);
        end
        advance();
        drive(0, '0, 0, 0, 0, '0, 0, 1);
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== 30'h3E00_0000 || bus.res_src !== 1'b0) begin
            errors++;
            $display("[TB] FAIL align_result: got v=%b d=%h s=%b expected v=1 d=3e000000 s=0",
                     bus.res_valid, bus.res_data, bus.res_src);
        end
    endtask

    task automatic test_norm_basic();
        drive(0, '0, 0, 0, 1, 30'h0000_0001, 5, 1);
        checks++;
        if (bus.norm_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL norm_ready: got %b expected 1", bus.norm_ready);
        end
        advance();
        drive(0, '0, 0, 0, 0, '0, 0, 1);
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== 30'h0000_0020 || bus.res_src !== 1'b1) begin
            errors++;
            $display("[TB] FAIL norm_result: got v=%b d=%h s=%b expected v=1 d=00000020 s=1",
                     bus.res_valid, bus.res_data, bus.res_src);
        end
    endtask

    task automatic test_saturation();
        bit           right_tab [3] = '{1'b1, 1'b1, 1'b0};
        bit           arith_tab [3] = '{1'b1, 1'b0, 1'b0};
        logic [W-1:0] exp_tab   [3] = '{30'h3FFF_FFFF, 30'h0, 30'h0};
        for (int i = 0; i < 3; i++) begin
            if (right_tab[i]) drive(1, 30'h3FFF_FFFF, 40, arith_tab[i], 0, '0, 0, 1);
            else              drive(0, '0, 0, 0, 1, 30'h3FFF_FFFF, 40, 1);
            advance();
            drive(0, '0, 0, 0, 0, '0, 0, 1);
            checks++;
            if (bus.res_data !== exp_tab[i] || bus.res_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL saturation_%0d: got v=%b d=%h expected v=1 d=%h",
                         i, bus.res_valid, bus.res_data, exp_tab[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit exp_src;
        rst = 1'b1;
        drive(0, '0, 0, 0, 0, '0, 0, 1);
        advance();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1, W'($urandom), $urandom_range(0, 35), 1'($urandom),
                  1, W'($urandom), $urandom_range(0, 35), 1);
            advance();
`ifdef SHIFT_ARB_RR_EN
            exp_src = (i % 2 == 1);
`else
            exp_src = 1'b0;
`endif
            checks++;
            if (bus.res_valid !== 1'b1 || bus.res_src !== exp_src || bus.res_data !== m_data) begin
                errors++;
                $display("[TB] FAIL back_to_back_%0d: got v=%b s=%b d=%h expected v=1 s=%b d=%h",
                         i, bus.res_valid, bus.res_src, bus.res_data, exp_src, m_data);
            end
        end
        drive(0, '0, 0, 0, 0, '0, 0, 1);
    endtask

    task automatic test_stall();
        logic [W-1:0] held;
        bit           ea;
        bit           en;
        drive(1, W'($urandom), 3, 0, 0, '0, 0, 1);
        advance();
        held = bus.res_data;
        for (int i = 0; i < 3; i++) begin
            drive(1, W'($urandom), $urandom_range(0, 29), 1'($urandom),
                  1, W'($urandom), $urandom_range(0, 29), 0);
            checks++;
            if ({bus.align_ready, bus.norm_ready} !== 2'b00) begin
                errors++;
                $display("[TB] FAIL stall_readys_%0d: got %b expected 00", i,
                         {bus.align_ready, bus.norm_ready});
            end
            advance();
            checks++;
            if (bus.res_valid !== 1'b1 || bus.res_data !== held) begin
                errors++;
                $display("[TB] FAIL stall_hold_%0d: got v=%b d=%h expected v=1 d=%h",
                         i, bus.res_valid, bus.res_data, held);
            end
        end
        bus.res_ready = 1'b1;
        #1;
        predict(ea, en);
        checks++;
        if ({bus.align_ready, bus.norm_ready} !== {ea, en} || (ea == en)) begin
            errors++;
            $display("[TB] FAIL stall_release_readys: got %b expected %b",
                     {bus.align_ready, bus.norm_ready}, {ea, en});
        end
        advance();
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== m_data || bus.res_src !== m_src) begin
            errors++;
            $display("[TB] FAIL stall_release_result: got v=%b s=%b d=%h expected v=1 s=%b d=%h",
                     bus.res_valid, bus.res_src, bus.res_data, m_src, m_data);
        end
        drive(0, '0, 0, 0, 0, '0, 0, 1);
    endtask

    task automatic test_reset_stall();
        drive(1, 30'h0ABC_DEF1, 1, 0, 0, '0, 0, 1);
        advance();
        drive(0, '0, 0, 0, 0, '0, 0, 0);
        advance();
        rst = 1'b1;
        advance();
        rst = 1'b0;
        checks++;
        if (bus.res_valid !== 1'b0 || bus.res_data !== '0) begin
            errors++;
            $display("[TB] FAIL reset_stall: got v=%b d=%h expected v=0 d=0", bus.res_valid, bus.res_data);
        end
        drive(1, 30'h0000_0100, 2, 0, 1, 30'h0000_0001, 2, 1);
        checks++;
        if ({bus.align_ready, bus.norm_ready} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL first_tie_readys: got %b expected 10", {bus.align_ready, bus.norm_ready});
        end
        advance();
        checks++;
        if (bus.res_src !== 1'b0 || bus.res_data !== 30'h0000_0040) begin
            errors++;
            $display("[TB] FAIL first_tie_result: got s=%b d=%h expected s=0 d=00000040",
                     bus.res_src, bus.res_data);
        end
        drive(0, '0, 0, 0, 0, '0, 0, 1);
    endtask

    task automatic test_random();
        bit ea;
        bit en;
        int aamt;
        int namt;
        for (int i = 0; i < 300; i++) begin
            aamt = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 511) : $urandom_range(0, 31);
            namt = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 511) : $urandom_range(0, 31);
            drive(1'($urandom), W'($urandom), aamt, 1'($urandom),
                  1'($urandom), W'($urandom), namt, ($urandom_range(0, 3) != 0));
            predict(ea, en);
            if (bus.align_valid) begin
                checks++;
                if (bus.align_ready !== ea) begin
                    errors++;
                    $display("[TB] FAIL random_align_ready_%0d: got %b expected %b", i, bus.align_ready, ea);
                end
            end
            if (bus.norm_valid) begin
                checks++;
                if (bus.norm_ready !== en) begin
                    errors++;
                    $display("[TB] FAIL random_norm_ready_%0d: got %b expected %b", i, bus.norm_ready, en);
                end
            end
            advance();
            checks++;
            if (bus.res_valid !== m_valid || bus.res_src !== m_src || bus.res_data !== m_data) begin
                errors++;
                $display("[TB] FAIL random_result_%0d: got v=%b s=%b d=%h expected v=%b s=%b d=%h",
                         i, bus.res_valid, bus.res_src, bus.res_data, m_valid, m_src, m_data);
            end
        end
        drive(0, '0, 0, 0, 0, '0, 0, 1);
    endtask

    // Run every scenario in sequence, then report.
    initial begin
        m_valid     = 1'b0;
        m_data      = '0;
        m_src       = 1'b0;
        m_last_norm = 1'b1;
        test_reset();
        test_align_basic();
        test_norm_basic();
        test_saturation();
        test_back_to_back();
        test_stall();
        test_reset_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
